// File: rtl/pipe_stage_reg_pkg.sv
// Shared types for the elastic pipeline stage: default MEM->WB payload layout and stage state encoding.
package pipe_stage_reg_pkg;

    localparam int WB_DATA_W     = 32;
    localparam int WB_ADDR_W     = 5;
    localparam int PC_W          = 32;
    localparam int INSTR_W       = 32;
    localparam int PAYLOAD_W     = WB_DATA_W + WB_ADDR_W + PC_W + INSTR_W + 1;

    // Producers pack the default payload through this struct; wb_data occupies the top bits.
    typedef struct packed {
        logic [WB_DATA_W-1:0] wb_data;
        logic [WB_ADDR_W-1:0] wb_addr;
        logic [PC_W-1:0]      pc;
        logic [INSTR_W-1:0]   instr;
        logic                 is_write_rf;
    } wb_payload_t;

    // Encoding is {skid_v, main_v}; 2'b10 would mean a skid entry without a main entry.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } stage_state_e;

    function automatic logic [1:0] occ_of(input stage_state_e st);
        logic [1:0] occ;
        case (st)
            ST_EMPTY: occ = 2'd0;
            ST_ONE:   occ = 2'd1;
            ST_FULL:  occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready payload channel used on both sides of a pipeline stage.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 102
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous reset; sticks at all-ones.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_r;

    // Count register: clear on reset, increment until saturated.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (inc && (count_r != {CNT_W{1'b1}})) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipe_stage_reg_chk.sv
// Simulation checks for the stage: skid entry never without main entry; stalled output stays stable.
module pipe_stage_reg_chk #(
    parameter int DATA_W = 102
) (
    input logic              clk,
    input logic              rst,
    input logic              flush,
    input logic              main_v,
    input logic              skid_v,
    input logic              out_valid,
    input logic              out_ready,
    input logic [DATA_W-1:0] out_data
);

    a_skid_implies_main: assert property (@(posedge clk) disable iff (rst) (skid_v |-> main_v));

    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: 2-entry skid buffer (registered in_ready) or single register,
// with flush and a saturating bubble counter for performance debug.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W     = PAYLOAD_W,
    parameter int SKID       = 1,
    parameter int CLEAR_DATA = 0,
    parameter int CNT_W      = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                flush,
    pipe_stage_reg_if.slave     in_bus,
    pipe_stage_reg_if.master    out_bus,
    output logic [1:0]          occupancy,
    output logic [CNT_W-1:0]    bubble_cnt
);

    stage_state_e      state_r;
    stage_state_e      state_s;
    logic [DATA_W-1:0] main_r;
    logic [DATA_W-1:0] main_s;
    logic [DATA_W-1:0] skid_r;
    logic [DATA_W-1:0] skid_s;
    logic              in_ready_r;
    logic              in_ready_s;
    logic              out_valid_s;
    logic              in_xfer_s;
    logic              out_xfer_s;
    logic              bubble_inc_s;

    assign out_valid_s  = (state_r != ST_EMPTY);
    // Without the skid entry, ready must see downstream ready combinationally to avoid losing throughput.
    assign in_ready_s   = (SKID != 0) ? in_ready_r : (~out_valid_s | out_bus.ready);
    assign in_xfer_s    = in_bus.valid & in_ready_s;
    assign out_xfer_s   = out_valid_s & out_bus.ready;
    assign bubble_inc_s = out_bus.ready & ~out_valid_s & ~flush;

    // Next-state and next-payload selection for the two-entry stage.
    always_comb begin
        state_s = state_r;
        main_s  = main_r;
        skid_s  = skid_r;
        if (flush) begin
            state_s = ST_EMPTY;
            if (CLEAR_DATA != 0) begin
                main_s = '0;
                skid_s = '0;
            end else begin
                main_s = main_r;
                skid_s = skid_r;
            end
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        state_s = ST_ONE;
                        main_s  = in_bus.data;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_xfer_s && out_xfer_s) begin
                        state_s = ST_ONE;
                        main_s  = in_bus.data;
                    end else if (in_xfer_s) begin
                        if (SKID != 0) begin
                            state_s = ST_FULL;
                            skid_s  = in_bus.data;
                        end else begin
                            state_s = ST_ONE;
                            main_s  = in_bus.data;
                        end
                    end else if (out_xfer_s) begin
                        state_s = ST_EMPTY;
                    end else begin
                        state_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (out_xfer_s) begin
                        state_s = ST_ONE;
                        main_s  = skid_r;
                    end else begin
                        state_s = ST_FULL;
                    end
                end
                default: begin
                    state_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Control state and registered ready; reset overrides flush and all transfers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r    <= ST_EMPTY;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_s;
            in_ready_r <= (state_s != ST_FULL);
        end
    end

    // Payload registers; reset only touches them when data clearing is enabled.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            if (CLEAR_DATA != 0) begin
                main_r <= '0;
                skid_r <= '0;
            end else begin
                main_r <= main_r;
                skid_r <= skid_r;
            end
        end else begin
            main_r <= main_s;
            skid_r <= skid_s;
        end
    end

    assign in_bus.ready  = in_ready_s;
    assign out_bus.valid = out_valid_s;
    assign out_bus.data  = main_r;
    assign occupancy     = occ_of(state_r);

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .inc   (bubble_inc_s),
        .count (bubble_cnt)
    );

    pipe_stage_reg_chk #(
        .DATA_W (DATA_W)
    ) u_chk (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .flush     (flush),
        .main_v    (state_r[0]),
        .skid_v    (state_r[1]),
        .out_valid (out_valid_s),
        .out_ready (out_bus.ready),
        .out_data  (main_r)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: instance A (skid, clear-data, 4-bit counter) and B (no skid, 16-bit counter)
// share stimulus; a queue-level model checks both every cycle, plus a directed table for A.
module tb_pipe_stage_reg;

    localparam int DW = 102;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          fl;
    logic          iv;
    logic          ordy;
    logic [DW-1:0] id;

    pipe_stage_reg_if #(.DATA_W(DW)) ia_in ();
    pipe_stage_reg_if #(.DATA_W(DW)) ia_out ();
    pipe_stage_reg_if #(.DATA_W(DW)) ib_in ();
    pipe_stage_reg_if #(.DATA_W(DW)) ib_out ();

    logic [1:0]  occ_a;
    logic [1:0]  occ_b;
    logic [3:0]  bub_a;
    logic [15:0] bub_b;

    assign ia_in.valid  = iv;
    assign ia_in.data   = id;
    assign ia_out.ready = ordy;
    assign ib_in.valid  = iv;
    assign ib_in.data   = id;
    assign ib_out.ready = ordy;

    pipe_stage_reg #(.DATA_W(DW), .SKID(1), .CLEAR_DATA(1), .CNT_W(4)) u_dut_a (
        .sys_clk    (clk),
        .sys_rst    (rst),
        .flush      (fl),
        .in_bus     (ia_in),
        .out_bus    (ia_out),
        .occupancy  (occ_a),
        .bubble_cnt (bub_a)
    );

    pipe_stage_reg #(.DATA_W(DW), .SKID(0), .CLEAR_DATA(0), .CNT_W(16)) u_dut_b (
        .sys_clk    (clk),
        .sys_rst    (rst),
        .flush      (fl),
        .in_bus     (ib_in),
        .out_bus    (ib_out),
        .occupancy  (occ_b),
        .bubble_cnt (bub_b)
    );

    logic          dir [2];
    logic          dov [2];
    logic [DW-1:0] dod [2];
    logic [1:0]    docc [2];
    logic [15:0]   dbub [2];
    assign dir[0]  = ia_in.ready;
    assign dir[1]  = ib_in.ready;
    assign dov[0]  = ia_out.valid;
    assign dov[1]  = ib_out.valid;
    assign dod[0]  = ia_out.data;
    assign dod[1]  = ib_out.data;
    assign docc[0] = occ_a;
    assign docc[1] = occ_b;
    assign dbub[0] = {12'd0, bub_a};
    assign dbub[1] = bub_b;

    // Reference model: each instance is a FIFO of capacity 2 (A) or 1 (B).
    logic [DW-1:0] mq [2][2];
    int            msz [2];
    int            mbub [2];
    logic [DW-1:0] mshow [2];
    bit            mknown [2];
    int            bmax [2];
    bit            clr [2];
    bit            armed;

    int checks;
    int failures;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_ir(input int k);
        if (k == 0) return (msz[0] < 2);
        return (msz[1] == 0) || (ordy == 1'b1);
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit ix;
            bit ox;
            ix = iv && exp_ir(k);
            ox = (msz[k] > 0) && ordy;
            if (rst) begin
                msz[k]  = 0;
                mbub[k] = 0;
                if (clr[k]) begin
                    mshow[k]  = '0;
                    mknown[k] = 1'b1;
                end
            end else begin
                if (ordy && (msz[k] == 0) && !fl && (mbub[k] < bmax[k])) mbub[k]++;
                if (fl) begin
                    msz[k] = 0;
                    if (clr[k]) begin
                        mshow[k]  = '0;
                        mknown[k] = 1'b1;
                    end
                end else begin
                    if (ox) begin
                        mq[k][0] = mq[k][1];
                        msz[k]--;
                    end
                    if (ix) begin
                        mq[k][msz[k]] = id;
                        msz[k]++;
                    end
                end
            end
            if (msz[k] > 0) begin
                mshow[k]  = mq[k][0];
                mknown[k] = 1'b1;
            end
        end
        if (rst) armed = 1'b1;
    endtask

    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("m%0d_out_valid", k), dov[k], msz[k] > 0);
            chk($sformatf("m%0d_occupancy", k), docc[k], msz[k][1:0]);
            chk($sformatf("m%0d_bubble_cnt", k), dbub[k], mbub[k][15:0]);
            chk($sformatf("m%0d_in_ready_post", k), dir[k], exp_ir(k));
            if (mknown[k]) chk($sformatf("m%0d_out_data", k), dod[k], mshow[k]);
        end
    endtask

    // One clock: inputs already driven while clk is low.
    task automatic cycle();
        #1;
        if (armed) begin
            for (int k = 0; k < 2; k++) chk($sformatf("m%0d_in_ready_pre", k), dir[k], exp_ir(k));
        end
        @(posedge clk);
        model_step();
        #1;
        if (armed) check_model();
        @(negedge clk);
    endtask

    task automatic drive(input bit r, input bit f, input bit v, input logic [DW-1:0] d, input bit o);
        rst = r; fl = f; iv = v; id = d; ordy = o;
    endtask

    typedef struct {
        bit            rst;
        bit            fl;
        bit            iv;
        logic [DW-1:0] id;
        bit            ordy;
        bit            e_ov;
        logic [DW-1:0] e_od;
        logic [1:0]    e_occ;
        bit            e_ir;
    } vec_t;

    vec_t tv[$];

    function automatic void add(input bit r, input bit f, input bit v, input logic [DW-1:0] d, input bit o,
                                input bit eov, input logic [DW-1:0] eod, input logic [1:0] eocc, input bit eir);
        vec_t e;
        e.rst = r; e.fl = f; e.iv = v; e.id = d; e.ordy = o;
        e.e_ov = eov; e.e_od = eod; e.e_occ = eocc; e.e_ir = eir;
        tv.push_back(e);
    endfunction

    initial begin
        logic [127:0] rnd;
        checks = 0; failures = 0; armed = 1'b0;
        bmax[0] = 15; bmax[1] = 65535;
        clr[0] = 1'b1; clr[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            msz[k] = 0; mbub[k] = 0; mknown[k] = 1'b0; mshow[k] = '0;
        end
        drive(1'b1, 1'b0, 1'b1, 102'h55, 1'b0);

        // reset held two cycles with in_valid high
        add(1, 0, 1, 102'h55, 0,  0, 102'h0, 2'd0, 1);
        add(1, 0, 1, 102'h55, 0,  0, 102'h0, 2'd0, 1);
        // streaming 1..10, one cycle latency
        for (int i = 1; i <= 10; i++) add(0, 0, 1, DW'(i), 1,  1, DW'(i), 2'd1, 1);
        add(0, 0, 0, 102'h0, 1,  0, 102'd10, 2'd0, 1);
        // stall fills skid, 0xC held upstream, then drains in order
        add(0, 0, 1, 102'hA, 0,  1, 102'hA, 2'd1, 1);
        add(0, 0, 1, 102'hB, 0,  1, 102'hA, 2'd2, 0);
        add(0, 0, 1, 102'hC, 0,  1, 102'hA, 2'd2, 0);
        add(0, 0, 1, 102'hC, 1,  1, 102'hB, 2'd1, 1);
        add(0, 0, 1, 102'hC, 1,  1, 102'hC, 2'd1, 1);
        add(0, 0, 0, 102'h0, 1,  0, 102'hC, 2'd0, 1);
        // flush while full, incoming 0xD dropped, data cleared
        add(0, 0, 1, 102'hE1, 0,  1, 102'hE1, 2'd1, 1);
        add(0, 0, 1, 102'hE2, 0,  1, 102'hE1, 2'd2, 0);
        add(0, 1, 1, 102'hD, 0,   0, 102'h0, 2'd0, 1);
        add(0, 0, 0, 102'h0, 1,   0, 102'h0, 2'd0, 1);
        // reset beats flush and transfers while full
        add(0, 0, 1, 102'h71, 0,  1, 102'h71, 2'd1, 1);
        add(0, 0, 1, 102'h72, 0,  1, 102'h71, 2'd2, 0);
        add(1, 1, 1, 102'h73, 1,  0, 102'h0, 2'd0, 1);
        add(0, 0, 0, 102'h0, 0,   0, 102'h0, 2'd0, 1);

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst, tv[i].fl, tv[i].iv, tv[i].id, tv[i].ordy);
            cycle();
            chk($sformatf("tv%0d_out_valid", i), dov[0], tv[i].e_ov);
            chk($sformatf("tv%0d_out_data", i), dod[0], tv[i].e_od);
            chk($sformatf("tv%0d_occupancy", i), docc[0], tv[i].e_occ);
            chk($sformatf("tv%0d_in_ready", i), dir[0], tv[i].e_ir);
        end

        // bubble counter saturation: A saturates at 15, B keeps counting; flush cycles don't count
        drive(1'b1, 1'b0, 1'b0, 102'h0, 1'b1);
        cycle();
        chk("bubble_after_reset_a", dbub[0], 16'd0);
        drive(1'b0, 1'b0, 1'b0, 102'h0, 1'b1);
        for (int i = 0; i < 20; i++) cycle();
        chk("bubble_sat_a", dbub[0], 16'd15);
        chk("bubble_cnt_b", dbub[1], 16'd20);
        drive(1'b0, 1'b1, 1'b0, 102'h0, 1'b1);
        cycle();
        chk("bubble_flush_b", dbub[1], 16'd20);

        // randomized traffic with occasional flush and reset
        for (int n = 0; n < 3000; n++) begin
            rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 3) != 0), rnd[DW-1:0], ($urandom_range(0, 2) != 0));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
